// File: rtl/alu32.sv
// -----------------------------------------------------------------------------
// alu32 -- registered 32-bit integer ALU for the RISC-V execute stage.
//
// Operands and opcode are sampled on every rising clock edge. Result and flags
// appear from registers one cycle later. No state carries between operations.
// The compare flags (u_slt, s_slt) are computed on every cycle from the
// operands alone, independent of alu_op, so branch logic can always use them.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst_n         in   1   asynchronous active-low reset (clears all outputs)
//   dataA         in  32   operand A (rs1 / shift source)
//   dataB         in  32   operand B (rs2 / immediate / shift amount in [4:0])
//   alu_op        in   3   operation select (see alu_op_e)
//   alu_out_data  out 32   registered result
//   zero          out  1   registered, result == 0
//   overflow      out  1   registered two's-complement overflow of ADD/SUB
//   u_slt         out  1   registered, dataA < dataB unsigned
//   s_slt         out  1   registered, dataA < dataB signed
// -----------------------------------------------------------------------------
module alu32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [2:0]  alu_op,
  output logic [31:0] alu_out_data,
  output logic        zero,
  output logic        overflow,
  output logic        u_slt,
  output logic        s_slt
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_AND = 3'b100,
    OP_SRA = 3'b101,
    OP_SRL = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  alu_op_e     op;
  logic [4:0]  shamt;
  logic [31:0] add_r;
  logic [32:0] sub_full;
  logic [31:0] sub_r;
  logic        add_ovf;
  logic        sub_ovf;

  logic [31:0] result_d, result_q;
  logic        zero_d, zero_q;
  logic        ovf_d, ovf_q;
  logic        u_slt_d, u_slt_q;
  logic        s_slt_d, s_slt_q;

  assign op    = alu_op_e'(alu_op);
  // Only the low five bits select the shift; a shift by 32 acts as a shift by 0.
  assign shamt = dataB[4:0];

  // Adder carry-out is discarded.
  assign add_r   = dataA + dataB;
  // Subtract as A + ~B + 1 on 33 bits; bit 32 is the carry, whose inverse is
  // the unsigned borrow (A < B).
  assign sub_full = {1'b0, dataA} + {1'b0, ~dataB} + 33'd1;
  assign sub_r    = sub_full[31:0];

  assign add_ovf = (dataA[31] == dataB[31]) && (add_r[31] != dataA[31]);
  assign sub_ovf = (dataA[31] != dataB[31]) && (sub_r[31] != dataA[31]);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    result_d = '0;
    ovf_d    = 1'b0;
    unique case (op)
      OP_ADD: begin
        result_d = add_r;
        ovf_d    = add_ovf;
      end
      OP_SUB: begin
        result_d = sub_r;
        ovf_d    = sub_ovf;
      end
      OP_OR:  result_d = dataA | dataB;
      OP_XOR: result_d = dataA ^ dataB;
      OP_AND: result_d = dataA & dataB;
      OP_SRA: result_d = $unsigned($signed(dataA) >>> shamt);
      OP_SRL: result_d = dataA >> shamt;
      OP_SLL: result_d = dataA << shamt;
      default: result_d = '0;
    endcase

    zero_d  = (result_d == 32'h0);
    u_slt_d = ~sub_full[32];
    // Sign of the difference corrected by overflow: valid over the full range.
    s_slt_d = sub_r[31] ^ sub_ovf;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      u_slt_q  <= 1'b0;
      s_slt_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      u_slt_q  <= u_slt_d;
      s_slt_q  <= s_slt_d;
    end
  end

  assign alu_out_data = result_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign u_slt        = u_slt_q;
  assign s_slt        = s_slt_q;

endmodule

// File: tb/tb_alu32.sv
// -----------------------------------------------------------------------------
// tb_alu32 -- self-checking bench for alu32.
// Directed cases plus randomized back-to-back operations compared against a
// behavioural reference model built on plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu32;

  logic        clk;
  logic        rst_n;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [2:0]  alu_op;
  logic [31:0] alu_out_data;
  logic        zero;
  logic        overflow;
  logic        u_slt;
  logic        s_slt;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected values for the operation currently being driven.
  logic [31:0] exp_r;
  logic        exp_z, exp_ov, exp_us, exp_ss;

  alu32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dataA        (dataA),
    .dataB        (dataB),
    .alu_op       (alu_op),
    .alu_out_data (alu_out_data),
    .zero         (zero),
    .overflow     (overflow),
    .u_slt        (u_slt),
    .s_slt        (s_slt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: integer arithmetic on the operand values themselves.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb, wide;
    int     amt;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    amt    = int'(b % 32);
    exp_ov = 1'b0;
    case (op)
      3'd0: begin
        wide   = sa + sb;
        exp_r  = a + b;
        exp_ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'd1: begin
        wide   = sa - sb;
        exp_r  = a - b;
        exp_ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'd2: exp_r = a | b;
      3'd3: exp_r = a ^ b;
      3'd4: exp_r = a & b;
      3'd5: exp_r = 32'(sa / (64'sd1 << amt) - ((sa < 0 && (sa % (64'sd1 << amt)) != 0) ? 1 : 0));
      3'd6: exp_r = 32'(longint'(a) / (64'sd1 << amt));
      default: exp_r = 32'(longint'(a) * (64'sd1 << amt));
    endcase
    exp_z  = (exp_r == 32'd0);
    exp_us = (longint'(a) < longint'(b));
    exp_ss = (sa < sb);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    dataA  = a;
    dataB  = b;
    alu_op = op;
    model(a, b, op);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".res"}, alu_out_data, exp_r);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_z});
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ov});
    check({tag, ".uslt"}, {31'd0, u_slt}, {31'd0, exp_us});
    check({tag, ".sslt"}, {31'd0, s_slt}, {31'd0, exp_ss});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".res"}, alu_out_data, 32'd0);
    check({tag, ".flags"}, {28'd0, zero, overflow, u_slt, s_slt}, 32'd0);
  endtask

  // Drive at the falling edge, then check just after the next rising edge.
  // With glitch set, the inputs are scrambled mid-cycle and the registered
  // outputs must not move.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input bit glitch);
    @(negedge clk);
    drive(a, b, op);
    @(posedge clk);
    #1;
    check_all(tag);
    if (glitch) begin
      dataA  = $urandom;
      dataB  = $urandom;
      alu_op = 3'($urandom);
      #2;
      check_all({tag, ".hold"});
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [8];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                32'h8000_0000, 32'h8000_0001, 32'h0000_001F, 32'h0000_0020};
    if ($urandom_range(3) == 0) return corners[$urandom_range(7)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] sweep [8];
    sweep = '{32'd20, 32'd0, 32'd10, 32'd0, 32'd10, 32'd0, 32'd0, 32'd10240};

    // Reset: outputs cleared while rst_n low, even with a live operation.
    rst_n = 1'b0;
    drive(32'd5, 32'd7, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Opcode sweep with A=B=10 against fixed expected results.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("sweep%0d", i), 32'd10, 32'd10, 3'(i), 1'b0);
      check($sformatf("sweep%0d.const", i), alu_out_data, sweep[i]);
      check($sformatf("sweep%0d.zconst", i), {31'd0, zero},
            {31'd0, (i == 1 || i == 3 || i == 5 || i == 6)});
    end

    // Overflow and compare boundaries.
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h1, 3'd0, 1'b0);
    check("add_ovf.c", {alu_out_data[31:1], overflow}, {31'h4000_0000, 1'b1});
    run_op("sub_ovf",  32'h8000_0000, 32'h1, 3'd1, 1'b0);
    check("sub_ovf.c", {alu_out_data[31:1], overflow}, {31'h3FFF_FFFF, 1'b1});
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 3'd0, 1'b0);
    check("add_wrap.c", {28'd0, zero, overflow, u_slt, s_slt}, 32'b1001);
    run_op("and_noov", 32'hFFFF_FFFF, 32'h1, 3'd4, 1'b0);
    run_op("cmp_neg1", 32'hFFFF_FFFF, 32'h1, 3'd2, 1'b0);
    run_op("cmp_pos1", 32'h1, 32'hFFFF_FFFF, 3'd3, 1'b0);
    check("cmp_pos1.c", {30'd0, u_slt, s_slt}, 32'b10);

    // Shifts.
    run_op("sra4",  32'h8000_0000, 32'd4,  3'd5, 1'b0);
    check("sra4.c", alu_out_data, 32'hF800_0000);
    run_op("srl4",  32'h8000_0000, 32'd4,  3'd6, 1'b0);
    check("srl4.c", alu_out_data, 32'h0800_0000);
    run_op("sll31", 32'h1, 32'd31, 3'd7, 1'b0);
    check("sll31.c", alu_out_data, 32'h8000_0000);
    run_op("sll32", 32'h1, 32'd32, 3'd7, 1'b0);
    check("sll32.c", alu_out_data, 32'h1);
    run_op("sra_hi", 32'hF000_000F, 32'hFFFF_FFE3, 3'd5, 1'b0);

    // Mid-stream reset with a nonzero result held.
    run_op("pre_rst", 32'd5, 32'd7, 3'd0, 1'b0);
    drive(32'd100, 32'd23, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(posedge clk);
    #1;
    check_cleared("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'd100, 32'd23, 3'd1);
    @(posedge clk);
    #1;
    check_all("post_rst");

    // Randomized back-to-back operations, with mid-cycle input glitches.
    for (int i = 0; i < 300; i++) begin
      run_op($sformatf("rnd%0d", i), pick_operand(), pick_operand(),
             3'($urandom_range(7)), ($urandom_range(3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
